// File: rtl/tdm_demux8.sv
// Eight-slot serial TDM demultiplexer: hunts for a frame sync, collects eight
// qualified bits into a shadow register and publishes them as one complete frame.
module tdm_demux8 #(
    parameter bit SYNC_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       en,
    input  logic       sync,
    output logic       out0,
    output logic       out1,
    output logic       out2,
    output logic       out3,
    output logic       out4,
    output logic       out5,
    output logic       out6,
    output logic       out7,
    output logic       frame_valid,
    output logic [2:0] slot,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [6:0] shadow_q, shadow_d;
    logic [7:0] out_q, out_d;
    logic       frame_valid_q, frame_valid_d;
    logic       sync_err_q, sync_err_d;
    logic       locked_q, locked_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        out_d         = out_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (en) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        slot_d      = 3'd1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (sync) begin
                        // Early sync restarts the frame; stale shadow bits get overwritten before use.
                        sync_err_d  = (slot_q != 3'd0);
                        shadow_d[0] = din;
                        slot_d      = 3'd1;
                    end else if (slot_q == 3'd0) begin
                        sync_err_d = 1'b1;
                        if (SYNC_CHECK) begin
                            state_d = HUNT;
                            slot_d  = 3'd0;
                        end else begin
                            shadow_d[0] = din;
                            slot_d      = 3'd1;
                        end
                    end else if (slot_q == 3'd7) begin
                        out_d         = {din, shadow_q};
                        frame_valid_d = 1'b1;
                        slot_d        = 3'd0;
                    end else begin
                        shadow_d[slot_q] = din;
                        slot_d           = slot_q + 3'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= 3'd0;
            shadow_q      <= 7'd0;
            out_q         <= 8'd0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            out_q         <= out_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
        end
    end

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign out4        = out_q[4];
    assign out5        = out_q[5];
    assign out6        = out_q[6];
    assign out7        = out_q[7];
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: drives one stimulus stream into a SYNC_CHECK=1 and a
// SYNC_CHECK=0 instance and compares both against bit-queue reference models.
module tb_tdm_demux8;

    logic clk = 1'b0;
    logic rst, din, en, sync;

    logic [7:0] o1, o0;
    logic       fv1, fv0, lk1, lk0, se1, se0;
    logic [2:0] sl1, sl0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdm_demux8 #(.SYNC_CHECK(1'b1)) dut1 (
        .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
        .out0(o1[0]), .out1(o1[1]), .out2(o1[2]), .out3(o1[3]),
        .out4(o1[4]), .out5(o1[5]), .out6(o1[6]), .out7(o1[7]),
        .frame_valid(fv1), .slot(sl1), .locked(lk1), .sync_err(se1)
    );

    tdm_demux8 #(.SYNC_CHECK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
        .out0(o0[0]), .out1(o0[1]), .out2(o0[2]), .out3(o0[3]),
        .out4(o0[4]), .out5(o0[5]), .out6(o0[6]), .out7(o0[7]),
        .frame_valid(fv0), .slot(sl0), .locked(lk0), .sync_err(se0)
    );

    // Reference state: index 0 models SYNC_CHECK=0, index 1 models SYNC_CHECK=1.
    bit       m_run [2];
    bit       m_bits[2][$];
    bit [7:0] m_out [2];
    bit       m_fv  [2];
    bit       m_se  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_step(input int sc, input bit r, input bit e,
                                       input bit s, input bit d);
        m_fv[sc] = 1'b0;
        m_se[sc] = 1'b0;
        if (r) begin
            m_run[sc] = 1'b0;
            m_bits[sc].delete();
            m_out[sc] = 8'd0;
        end else if (e) begin
            if (!m_run[sc]) begin
                if (s) begin
                    m_bits[sc].delete();
                    m_bits[sc].push_back(d);
                    m_run[sc] = 1'b1;
                end
            end else if (s) begin
                m_se[sc] = (m_bits[sc].size() != 0);
                m_bits[sc].delete();
                m_bits[sc].push_back(d);
            end else if (m_bits[sc].size() == 0) begin
                m_se[sc] = 1'b1;
                if (sc == 1) m_run[sc] = 1'b0;
                else m_bits[sc].push_back(d);
            end else begin
                m_bits[sc].push_back(d);
                if (m_bits[sc].size() == 8) begin
                    for (int i = 0; i < 8; i++) m_out[sc][i] = m_bits[sc][i];
                    m_fv[sc] = 1'b1;
                    m_bits[sc].delete();
                end
            end
        end
    endfunction

    task automatic compare_all();
        check("sc1 out",    {24'd0, o1},  {24'd0, m_out[1]});
        check("sc1 fvalid", {31'd0, fv1}, {31'd0, m_fv[1]});
        check("sc1 syerr",  {31'd0, se1}, {31'd0, m_se[1]});
        check("sc1 locked", {31'd0, lk1}, {31'd0, m_run[1]});
        check("sc1 slot",   {29'd0, sl1}, m_bits[1].size());
        check("sc0 out",    {24'd0, o0},  {24'd0, m_out[0]});
        check("sc0 fvalid", {31'd0, fv0}, {31'd0, m_fv[0]});
        check("sc0 syerr",  {31'd0, se0}, {31'd0, m_se[0]});
        check("sc0 locked", {31'd0, lk0}, {31'd0, m_run[0]});
        check("sc0 slot",   {29'd0, sl0}, m_bits[0].size());
        check("excl fv/se", {30'd0, fv1 & se1, fv0 & se0}, 32'd0);
    endtask

    task automatic cyc(input bit r, input bit e, input bit s, input bit d);
        rst = r; en = e; sync = s; din = d;
        @(posedge clk);
        model_step(0, r, e, s, d);
        model_step(1, r, e, s, d);
        #1;
        compare_all();
    endtask

    task automatic send_frame(input bit [7:0] bits, input int max_gap);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, (i == 0), bits[i]);
            if (i < 7) begin
                int g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
                for (int k = 0; k < g; k++) cyc(1'b0, 1'b0, $urandom_range(1, 0), $urandom_range(1, 0));
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset out", {24'd0, o1}, 32'd0);
        check("reset locked/fv/se/slot", {26'd0, lk1, fv1, se1, sl1}, 32'd0);

        // After reset a bit without sync is ignored.
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("hunt ignores", {29'd0, lk1, sl1[1:0]}, 32'd0);

        // Basic frame 1,0,0,1,1,0,1,1 (out0 first).
        send_frame(8'b1101_1001, 0);
        check("frame out", {24'd0, o1}, 32'h0000_00D9);
        check("frame fv/lk/slot", {27'd0, fv1, lk1, sl1}, 32'b11_000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("fv one cycle", {31'd0, fv1}, 32'd0);

        // Same frame with en gaps.
        send_frame(8'b1101_1001, 3);
        check("gap frame out", {24'd0, o0}, 32'h0000_00D9);

        // Early sync at slot 4.
        send_frame(8'b0101_0101, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("early sync err", {30'd0, se1, se0}, 32'd3);
        check("early keep out", {24'd0, o1}, 32'h0000_0055);
        for (int i = 1; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, i[0]);
        check("early new frame", {24'd0, o1}, 32'h0000_00AB);

        // Missing sync at slot 0: SYNC_CHECK=1 drops lock, SYNC_CHECK=0 carries on.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("missing sync", {27'd0, se1, lk1, se0, lk0, 1'b0}, 32'b10110);
        for (int i = 1; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("sc0 completes", {24'd0, o0}, 32'h0000_00FE);
        check("sc1 still hunting", {28'd0, lk1, sl1}, 32'd0);

        // Reset mid-frame at slot 5 with en and sync high.
        send_frame(8'b1111_1111, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("midreset out", {16'd0, o1, o0}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("midreset no fv", {30'd0, fv1, fv0}, 32'd0);

        // Randomised traffic with sync mostly on slot boundaries.
        for (int n = 0; n < 4000; n++) begin
            bit e, s, r;
            e = ($urandom_range(3, 0) != 0);
            r = ($urandom_range(299, 0) == 0);
            if (m_bits[0].size() == 0) s = ($urandom_range(9, 0) != 0);
            else                       s = ($urandom_range(29, 0) == 0);
            cyc(r, e, s, $urandom_range(1, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
